// File: rtl/vga_pkg.sv
// Shared timing constants and colour/coordinate definitions for the VGA pipeline.
// The graphic stage imports the same coordinate width so x/y buses always match.
package vga_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned COLOR_W = 8;
  localparam logic [COLOR_W-1:0] COLOR_NULL = 8'h00;

  // 640x480@60 defaults
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Generic 0..MAX wrap counter with enable and synchronous clear.
// o_tc flags the terminal value so counters can be chained.
module vga_counter #(
  parameter int unsigned W   = 11,
  parameter int unsigned MAX = 1
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] L_MAX = W'(MAX);

  logic [W-1:0] r_cnt;

  // count register: clear wins, otherwise step and wrap on enable
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en) begin
      if (r_cnt == L_MAX) begin
        r_cnt <= {W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == L_MAX);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel divider, x/y beam counters, and a two-stage output
// pipeline that blanks the graphic stage's colour and re-aligns hsync/vsync with it.
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_tick,
  output logic               video_on,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync,
  output logic               vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = clog2_min1(CLK_DIV);

  localparam logic [COORD_W-1:0] L_H_ACTIVE = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] L_V_ACTIVE = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] L_HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] L_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] L_VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] L_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   w_div;
  logic               w_pix_tick;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_x_tc;
  logic               w_unused_y_tc;
  logic               w_video_on;
  logic               w_hs_raw;
  logic               w_vs_raw;

  logic               r_video_d1;
  logic               r_hs_d1;
  logic               r_vs_d1;
  logic [COLOR_W-1:0] r_rgb_out;
  logic               r_hsync;
  logic               r_vsync;

  vga_counter #(.W(DIV_W), .MAX(CLK_DIV - 1)) u_div (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (1'b1),
    .o_cnt (w_div),
    .o_tc  (w_pix_tick)
  );

  vga_counter #(.W(COORD_W), .MAX(H_TOTAL - 1)) u_x (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_pix_tick),
    .o_cnt (w_x),
    .o_tc  (w_x_tc)
  );

  // y only steps on the pixel tick that wraps x
  vga_counter #(.W(COORD_W), .MAX(V_TOTAL - 1)) u_y (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_pix_tick & w_x_tc),
    .o_cnt (w_y),
    .o_tc  (w_unused_y_tc)
  );

  assign w_video_on = (w_x < L_H_ACTIVE) && (w_y < L_V_ACTIVE);
  assign w_hs_raw   = (w_x >= L_HS_START) && (w_x < L_HS_END);
  assign w_vs_raw   = (w_y >= L_VS_START) && (w_y < L_VS_END);

  // stage 1: delay decodes to line up with the graphic stage's registered colour
  always_ff @(posedge clk) begin
    if (rst) begin
      r_video_d1 <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_vs_d1    <= 1'b0;
    end else begin
      r_video_d1 <= w_video_on;
      r_hs_d1    <= w_hs_raw;
      r_vs_d1    <= w_vs_raw;
    end
  end

  // stage 2: blank colour outside the active area and apply sync polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_out <= COLOR_NULL;
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
    end else begin
      r_rgb_out <= r_video_d1 ? rgb_in : COLOR_NULL;
      r_hsync   <= r_hs_d1 ? SYNC_POL : ~SYNC_POL;
      r_vsync   <= r_vs_d1 ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign x           = w_x;
  assign y           = w_y;
  assign pix_tick    = w_pix_tick;
  assign video_on    = w_video_on;
  assign frame_start = (w_x == {COORD_W{1'b0}}) && (w_y == {COORD_W{1'b0}})
                     && (w_div == {DIV_W{1'b0}}) && !rst;
  assign rgb_out     = r_rgb_out;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync using a shrunken 15x8-pixel timing so whole frames fit
// in a short run; k counts clks since the last reset release.
module tb_vga_sync;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int DIV = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x, y;
  logic        pix_tick, video_on, frame_start;
  logic [7:0]  rgb_in = 8'hFF;
  logic [7:0]  rgb_out;
  logic        hsync, vsync;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  bit pat_mode = 1'b0;

  typedef struct packed {
    logic [15:0] k;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        vo;
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vga_sync #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .SYNC_POL(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .pix_tick    (pix_tick),
    .video_on    (video_on),
    .frame_start (frame_start),
    .rgb_in      (rgb_in),
    .rgb_out     (rgb_out),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  function automatic int mx(input int kk);
    return (kk / DIV) % HT;
  endfunction

  function automatic int my(input int kk);
    return ((kk / DIV) / HT) % VT;
  endfunction

  function automatic bit mvo(input int kk);
    return (mx(kk) < HA) && (my(kk) < VA);
  endfunction

  function automatic logic [7:0] mcol(input int xx);
    return ((xx % 2) == 1) ? 8'hAA : 8'h55;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  // graphic-stage stand-in: colour of the previous clk's pixel, i.e. registered once
  task automatic drive_rgb();
    if (!pat_mode) rgb_in = 8'hFF;
    else if (k == 0) rgb_in = 8'h00;
    else rgb_in = mcol(mx(k - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    drive_rgb();
    #1;
  endtask

  task automatic add(input int kk, input int xx, input int yy, input bit fs, input bit vo,
                     input bit hs, input bit vs, input logic [7:0] rgb);
    vec_t v;
    v.k = 16'(kk); v.x = 11'(xx); v.y = 11'(yy);
    v.fs = fs; v.vo = vo; v.hs = hs; v.vs = vs; v.rgb = rgb;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_first, fs_second, hs_low, vs_low, guard;

    //   k    x  y fs vo hs vs rgb   (rgb_in held at FF)
    add(  0,  0, 0, 1, 1, 1, 1, 8'h00);
    add(  1,  0, 0, 0, 1, 1, 1, 8'h00);
    add(  2,  1, 0, 0, 1, 1, 1, 8'hFF);
    add( 15,  7, 0, 0, 1, 1, 1, 8'hFF);
    add( 16,  8, 0, 0, 0, 1, 1, 8'hFF);
    add( 17,  8, 0, 0, 0, 1, 1, 8'hFF);
    add( 18,  9, 0, 0, 0, 1, 1, 8'h00);
    add( 20, 10, 0, 0, 0, 1, 1, 8'h00);
    add( 21, 10, 0, 0, 0, 1, 1, 8'h00);
    add( 22, 11, 0, 0, 0, 0, 1, 8'h00);
    add( 27, 13, 0, 0, 0, 0, 1, 8'h00);
    add( 28, 14, 0, 0, 0, 1, 1, 8'h00);
    add( 30,  0, 1, 0, 1, 1, 1, 8'h00);
    add( 31,  0, 1, 0, 1, 1, 1, 8'h00);
    add( 32,  1, 1, 0, 1, 1, 1, 8'hFF);
    add(120,  0, 4, 0, 0, 1, 1, 8'h00);
    add(150,  0, 5, 0, 0, 1, 1, 8'h00);
    add(151,  0, 5, 0, 0, 1, 1, 8'h00);
    add(152,  1, 5, 0, 0, 1, 0, 8'h00);
    add(211,  0, 7, 0, 0, 1, 0, 8'h00);
    add(212,  1, 7, 0, 0, 1, 1, 8'h00);
    add(239, 14, 7, 0, 0, 1, 1, 8'h00);
    add(240,  0, 0, 1, 1, 1, 1, 8'h00);
    add(241,  0, 0, 0, 1, 1, 1, 8'h00);
    add(242,  1, 0, 0, 1, 1, 1, 8'hFF);

    // reset held 5 clks
    rst = 1'b1;
    drive_rgb();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("rst_fs_forced_low", {31'd0, frame_start}, 32'd0);
    chk("rst_x", {21'd0, x}, 32'd0);
    chk("rst_hsync", {31'd0, hsync}, 32'd1);
    chk("rst_rgb_out", {24'd0, rgb_out}, 32'd0);
    rst = 1'b0;
    k = 0;
    drive_rgb();
    #1;

    foreach (vecs[i]) begin
      while (k < int'(vecs[i].k)) tick();
      chk("x", {21'd0, x}, {21'd0, vecs[i].x});
      chk("y", {21'd0, y}, {21'd0, vecs[i].y});
      chk("frame_start", {31'd0, frame_start}, {31'd0, vecs[i].fs});
      chk("video_on", {31'd0, video_on}, {31'd0, vecs[i].vo});
      chk("hsync", {31'd0, hsync}, {31'd0, vecs[i].hs});
      chk("vsync", {31'd0, vsync}, {31'd0, vecs[i].vs});
      chk("rgb_out", {24'd0, rgb_out}, {24'd0, vecs[i].rgb});
      chk("pix_tick", {31'd0, pix_tick}, {31'd0, ((k % DIV) == (DIV - 1))});
    end

    // alternating colour pattern, frame spacing and sync pulse widths
    pat_mode = 1'b1;
    fs_first = -1;
    fs_second = -1;
    hs_low = 0;
    vs_low = 0;
    while (k < 720) begin
      tick();
      if (k >= 244)
        chk("pattern_rgb", {24'd0, rgb_out},
            {24'd0, (mvo(k - 2) ? mcol(mx(k - 2)) : 8'h00)});
      if (frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k >= 480 && hsync === 1'b0) hs_low++;
      if (k >= 480 && vsync === 1'b0) vs_low++;
    end
    chk("fs_first_at", fs_first, 32'd480);
    chk("fs_period", fs_second - fs_first, 32'(HT * VT * DIV));
    chk("hsync_low_per_frame", hs_low, 32'(VT * HS * DIV));
    chk("vsync_low_per_frame", vs_low, 32'(VS * HT * DIV));

    // reset in the middle of both sync pulses
    guard = 0;
    while (!(mx(k) == 12 && my(k) == 6 && (k % DIV) == 0) && guard < 500) begin
      tick();
      guard++;
    end
    chk("midrst_reached", {31'd0, (guard < 500)}, 32'd1);
    chk("midrst_pre_x", {21'd0, x}, 32'd12);
    chk("midrst_pre_y", {21'd0, y}, 32'd6);
    chk("midrst_pre_hsync", {31'd0, hsync}, 32'd0);
    chk("midrst_pre_vsync", {31'd0, vsync}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_x", {21'd0, x}, 32'd0);
    chk("midrst_y", {21'd0, y}, 32'd0);
    chk("midrst_hsync", {31'd0, hsync}, 32'd1);
    chk("midrst_vsync", {31'd0, vsync}, 32'd1);
    chk("midrst_fs_forced_low", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    k = 0;
    drive_rgb();
    #1;
    chk("restart_fs", {31'd0, frame_start}, 32'd1);
    chk("restart_rgb_out", {24'd0, rgb_out}, 32'd0);
    tick();
    tick();
    chk("restart_x_after_2", {21'd0, x}, 32'd1);
    chk("restart_rgb_pattern", {24'd0, rgb_out}, {24'd0, mcol(0)});
    guard = 0;
    while (frame_start !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    chk("restart_next_fs_at", k, 32'(HT * VT * DIV));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Upstream timing stage for the pong pixel pipeline.
- Divides the system clock into a pixel tick and runs horizontal/vertical counters.
- Drives the 11-bit x/y beam coordinates consumed by the graphic stage.
- Takes back that stage's registered 8-bit colour, blanks it outside the active area and emits it with hsync/vsync re-aligned for the VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- SYNC_POL, 0, asserted level of hsync/vsync

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- x  out  11  horizontal counter (pixel column, 0..H_TOTAL-1)
- y  out  11  vertical counter (line, 0..V_TOTAL-1)
- pix_tick  out  1  high on last clk of each pixel period
- video_on  out  1  x<H_ACTIVE and y<V_ACTIVE
- frame_start  out  1  one-clk pulse, first clk of pixel (0,0)
- rgb_in  in  8  colour from graphic stage, [B1 B2 G1 G2 G3 R1 R2 R3]
- rgb_out  out  8  blanked, registered colour to DAC
- hsync  out  1  horizontal sync, pipeline-aligned with rgb_out
- vsync  out  1  vertical sync, pipeline-aligned with rgb_out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values:
  - div_cnt, x, y = 0; rgb_out = 0.
  - hsync, vsync = ~SYNC_POL.
  - frame_start forced 0 while rst is high.
  - Internal pipeline registers cleared to the blank/deasserted state.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - pix_tick = (div_cnt==CLK_DIV-1); constant 1 when CLK_DIV=1.
- Counters (advance only on pix_tick):
  - x increments; at x==H_TOTAL-1, x wraps to 0 and y advances.
  - y increments; at y==V_TOTAL-1 together with the x wrap, y wraps to 0.
  - All counters are 11-bit unsigned; no other wrap is possible.
- Hold time: x/y are registered and each value is stable for exactly CLK_DIV clks.
- frame_start = (x==0 && y==0 && div_cnt==0 && !rst), decoded from registered state.
  - Asserted on the first clk after reset release.
  - Then asserted once per frame, every H_TOTAL*V_TOTAL*CLK_DIV clks.
- video_on: combinational decode of x/y, same clk as x/y.
- Raw sync decode, from x/y:
  - hs_raw asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output alignment:
  - The graphic stage registers rgb one clk after x/y, so rgb_in for pixel (x,y) arrives 1 clk late.
  - Stage 1: delay video_on, hs_raw and vs_raw by one register.
  - Stage 2: rgb_out <= video_on_d1 ? rgb_in : 0; hsync <= hs_d1 ? SYNC_POL : ~SYNC_POL; same for vsync.
  - Total latency from x/y change to hsync/vsync/rgb_out: 2 clks. rgb_out is 1 clk after rgb_in.
- Boundaries:
  - x==H_ACTIVE-1 is the last visible pixel; x==H_ACTIVE is blanked and rgb_out is 0 even if rgb_in is nonzero.
  - The vsync window covers whole lines: it asserts and deasserts at x==0 of the corresponding line, delayed by 2 clks.
  - Reset mid-line: on the next clk all counters return to 0 and syncs deassert. No partial sync pulse is extended; the truncated pulse ends at reset.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (640x480@60 defaults);
  - the COLOR_NULL value (8'h00);
  - the 11-bit coordinate width, also used by the graphic stage.
- One natural sub-module, vga_counter: a generic wrap counter with enable, terminal-count output and sync clear. It is instantiated for the divider, for x and for y.

Test Plan:
- Reset/start: hold rst 5 clks, release -> frame_start=1 on the first clk; x=0, y=0; hsync=vsync=1; rgb_out=0.
- Line timing, CLK_DIV=2:
  - x==1 after 2 clks.
  - y increments every 1600 clks.
  - hsync low for exactly 192 clks, beginning 2 clks after x becomes 656.
- Frame timing: frame_start pulses are 840000 clks apart; vsync low for 3200 clks, beginning 2 clks after y becomes 490 with x=0.
- Blanking: drive rgb_in=8'hFF constantly -> rgb_out=FF while the delayed video_on is high, and 0 from 2 clks after x==640 until 2 clks after x returns to 0.
- Pipeline alignment: model rgb_in = (x[0] ? 8'hAA : 8'h55) registered once -> rgb_out toggles with exact 2-clk lag relative to x, no glitch clks.
- Mid-frame reset: assert rst at x=700,y=491 for 1 clk -> next clk x=y=0, vsync and hsync deasserted, then normal frame_start restart.
